// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory for the fetch stage.
// A boot loader fills the array while the block is in S_LOAD. After ld_done the
// block serves registered 1-cycle fetches with stall/flush handling and a fault
// flag for misaligned or out-of-range PCs.
module instr_mem_sync #(
  parameter int          DEPTH         = 64,
  parameter logic [31:0] NOP           = 32'h0000_0013,
  parameter bit          LOAD_ON_RESET = 1'b1,
  parameter              INIT_FILE     = ""
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              A,
  input  logic                     fetch_en,
  input  logic                     stall,
  input  logic                     flush,
  output logic [31:0]              RD,
  output logic                     rd_valid,
  output logic                     fault,
  output logic                     ready,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  input  logic                     ld_done,
  output logic [$clog2(DEPTH):0]   ld_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam state_e RESET_STATE = LOAD_ON_RESET ? S_LOAD : S_RUN;

  state_e      state_q, state_d;
  logic [AW:0] ld_count_q, ld_count_d;
  logic [31:0] rd_q, rd_d;
  logic        rd_valid_q, rd_valid_d;
  logic        fault_q, fault_d;
  logic        bad_s;
  logic [31:0] mem_q [DEPTH];

  // Misaligned PC, or any address bit above the array range, is a fault (no aliasing).
  assign bad_s = (A[1:0] != 2'b00) | (A[31:AW+2] != '0);

  // Loader FSM next state and saturating count of accepted loader writes.
  always_comb begin
    state_d    = state_q;
    ld_count_d = ld_count_q;
    case (state_q)
      S_LOAD: begin
        if (ld_we && (ld_count_q != CNT_MAX)) begin
          ld_count_d = ld_count_q + CNT_ONE;
        end else begin
          ld_count_d = ld_count_q;
        end
        if (ld_done) begin
          state_d = S_RUN;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // Read path: flush beats stall beats fetch; nothing is fetched while loading.
  always_comb begin
    rd_d       = NOP;
    rd_valid_d = 1'b0;
    fault_d    = 1'b0;
    if (state_q != S_RUN) begin
      rd_d       = NOP;
      rd_valid_d = 1'b0;
      fault_d    = 1'b0;
    end else if (flush) begin
      rd_d       = NOP;
      rd_valid_d = 1'b0;
      fault_d    = 1'b0;
    end else if (stall) begin
      rd_d       = rd_q;
      rd_valid_d = rd_valid_q;
      fault_d    = fault_q;
    end else if (fetch_en) begin
      if (bad_s) begin
        rd_d       = NOP;
        rd_valid_d = 1'b0;
        fault_d    = 1'b1;
      end else begin
        rd_d       = mem_q[A[AW+1:2]];
        rd_valid_d = 1'b1;
        fault_d    = 1'b0;
      end
    end else begin
      rd_d       = NOP;
      rd_valid_d = 1'b0;
      fault_d    = 1'b0;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      ld_count_q <= '0;
      rd_q       <= NOP;
      rd_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_count_q <= ld_count_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
      fault_q    <= fault_d;
    end
  end

  // Loader write port; reset in the same cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == S_LOAD) && ld_we) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  assign RD       = rd_q;
  assign rd_valid = rd_valid_q;
  assign fault    = fault_q;
  assign ready    = (state_q == S_RUN);
  assign ld_count = ld_count_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync: fetch steps push their expected response,
// a negedge monitor pops and compares the registered outputs.
module tb_instr_mem_sync;

  localparam int          DEPTH = 64;
  localparam int          AW    = 6;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   A;
  logic          fetch_en, stall, flush;
  logic [31:0]   RD;
  logic          rd_valid, fault, ready;
  logic          ld_we, ld_done;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic [AW:0]   ld_count;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] rd;
    logic        v;
    logic        f;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  instr_mem_sync #(.DEPTH(DEPTH), .NOP(NOP), .LOAD_ON_RESET(1'b1), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .A(A), .fetch_en(fetch_en), .stall(stall), .flush(flush),
    .RD(RD), .rd_valid(rd_valid), .fault(fault), .ready(ready),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
    .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests_run++;
      if (RD !== e.rd || rd_valid !== e.v || fault !== e.f) begin
        tests_failed++;
        $display("FAIL %s: got RD=%h v=%b f=%b, want RD=%h v=%b f=%b",
                 e.name, RD, rd_valid, fault, e.rd, e.v, e.f);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One read-path cycle; expectation is queued for the output after the edge.
  task automatic step(input string name, input logic [31:0] a, input logic fe,
                      input logic st, input logic fl,
                      input logic [31:0] erd, input logic ev, input logic ef);
    exp_t e;
    A = a; fetch_en = fe; stall = st; flush = fl;
    @(posedge clk); #1;
    e.rd = erd; e.v = ev; e.f = ef; e.name = name;
    exp_q.push_back(e);
    fetch_en = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic ld(input logic we, input logic [AW-1:0] addr, input logic [31:0] data,
                    input logic done);
    ld_we = we; ld_addr = addr; ld_data = data; ld_done = done;
    @(posedge clk); #1;
    ld_we = 1'b0; ld_done = 1'b0;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    @(posedge clk); #1;
    chk({name, "_rd"}, RD, NOP);
    chk({name, "_valid"}, {31'd0, rd_valid}, 32'd0);
    chk({name, "_fault"}, {31'd0, fault}, 32'd0);
    chk({name, "_ready"}, {31'd0, ready}, 32'd0);
    chk({name, "_count"}, {25'd0, ld_count}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk); n++;
    end
    #1;
    chk("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b1; A = 32'd0; fetch_en = 1'b0; stall = 1'b0; flush = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = 32'd0; ld_done = 1'b0;
    @(posedge clk);
    // 1: reset state, load four words, ld_done
    do_reset("rst1");
    ld(1'b1, 6'd0, 32'h0050_0093, 1'b0);
    ld(1'b1, 6'd1, 32'h0030_0113, 1'b0);
    ld(1'b1, 6'd2, 32'h0020_81B3, 1'b0);
    ld(1'b1, 6'd3, NOP, 1'b0);
    chk("load_not_ready", {31'd0, ready}, 32'd0);
    chk("load_count", {25'd0, ld_count}, 32'd4);
    ld(1'b0, 6'd0, 32'd0, 1'b1);
    chk("done_ready", {31'd0, ready}, 32'd1);
    chk("done_count", {25'd0, ld_count}, 32'd4);
    // 2: back-to-back fetches
    step("fetch0", 32'h0, 1'b1, 1'b0, 1'b0, 32'h0050_0093, 1'b1, 1'b0);
    step("fetch4", 32'h4, 1'b1, 1'b0, 1'b0, 32'h0030_0113, 1'b1, 1'b0);
    step("fetch8", 32'h8, 1'b1, 1'b0, 1'b0, 32'h0020_81B3, 1'b1, 1'b0);
    step("idle",   32'h8, 1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0);
    // 3: stall holds, stall+flush kills
    step("fetch4b", 32'h4, 1'b1, 1'b0, 1'b0, 32'h0030_0113, 1'b1, 1'b0);
    step("stall1",  32'h0, 1'b1, 1'b1, 1'b0, 32'h0030_0113, 1'b1, 1'b0);
    step("stall2",  32'h8, 1'b0, 1'b1, 1'b0, 32'h0030_0113, 1'b1, 1'b0);
    step("stall3",  32'h0, 1'b1, 1'b1, 1'b0, 32'h0030_0113, 1'b1, 1'b0);
    step("stall_flush", 32'h0, 1'b1, 1'b1, 1'b1, NOP, 1'b0, 1'b0);
    // 4: misaligned and out-of-range faults, then clean fetch
    step("misalign",  32'h6,   1'b1, 1'b0, 1'b0, NOP, 1'b0, 1'b1);
    step("range",     32'h100, 1'b1, 1'b0, 1'b0, NOP, 1'b0, 1'b1);
    step("fault_clr", 32'h0,   1'b1, 1'b0, 1'b0, 32'h0050_0093, 1'b1, 1'b0);
    step("fault_stall", 32'h8000_0000, 1'b1, 1'b0, 1'b0, NOP, 1'b0, 1'b1);
    step("fault_held",  32'h0, 1'b1, 1'b1, 1'b0, NOP, 1'b0, 1'b1);
    step("fault_pulse", 32'h0, 1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0);
    step("fetch4c", 32'h4, 1'b1, 1'b0, 1'b0, 32'h0030_0113, 1'b1, 1'b0);
    drain();
    // 5: write+done same cycle; loader ignored in S_RUN
    do_reset("rst2");
    step("load_fetch_ign", 32'h0, 1'b1, 1'b0, 1'b0, NOP, 1'b0, 1'b0);
    ld(1'b1, 6'd5, 32'hDEAD_BEEF, 1'b1);
    chk("wd_ready", {31'd0, ready}, 32'd1);
    chk("wd_count", {25'd0, ld_count}, 32'd1);
    step("fetch14", 32'h14, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step("keep0",   32'h0,  1'b1, 1'b0, 1'b0, 32'h0050_0093, 1'b1, 1'b0);
    ld(1'b1, 6'd5, 32'h1234_5678, 1'b1);
    chk("run_count_hold", {25'd0, ld_count}, 32'd1);
    step("run_we_ign", 32'h14, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    drain();
    // 6: reset mid-load keeps partial data
    do_reset("rst3");
    ld(1'b1, 6'd0, 32'h1111_1111, 1'b0);
    ld(1'b1, 6'd1, 32'h2222_2222, 1'b0);
    chk("mid_count", {25'd0, ld_count}, 32'd2);
    reset = 1'b1; ld_we = 1'b1; ld_addr = 6'd2; ld_data = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    ld_we = 1'b0;
    do_reset("rst4");
    ld(1'b1, 6'd2, 32'h3333_3333, 1'b0);
    ld(1'b1, 6'd3, 32'h4444_4444, 1'b1);
    chk("reload_count", {25'd0, ld_count}, 32'd2);
    step("first_pass0", 32'h0, 1'b1, 1'b0, 1'b0, 32'h1111_1111, 1'b1, 1'b0);
    step("first_pass1", 32'h4, 1'b1, 1'b0, 1'b0, 32'h2222_2222, 1'b1, 1'b0);
    step("second_pass", 32'h8, 1'b1, 1'b0, 1'b0, 32'h3333_3333, 1'b1, 1'b0);
    step("still5",      32'h14, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
